// File: rtl/game_timing_pkg.sv
// Shared timing definitions for the gravity tick generator: FSM state type and
// default period constants (all periods in clk cycles).
package game_timing_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } tick_state_e;

    localparam int unsigned DEF_BASE_PERIOD = 10_000_000;
    localparam int unsigned DEF_PERIOD_STEP = 600_000;
    localparam int unsigned DEF_MIN_PERIOD  = 1_000_000;
    localparam int unsigned DEF_FAST_SHIFT  = 3;

endpackage

// File: rtl/tick_period_calc.sv
// Saturating period arithmetic: registered level period plus the soft-drop
// fast period derived from it.
module tick_period_calc
    import game_timing_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          LEVEL_W     = 4,
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned FAST_SHIFT  = DEF_FAST_SHIFT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               soft_drop_i,
    output logic [CNT_W-1:0]   eff_p_o
);

    localparam int W = CNT_W + LEVEL_W;

    logic [W-1:0]     base_w;
    logic [W-1:0]     min_w;
    logic [W-1:0]     reduce_w;
    logic [W-1:0]     lvl_w;
    logic [CNT_W-1:0] lvl_p_d;
    logic [CNT_W-1:0] lvl_p_q;
    logic [CNT_W-1:0] fast_p;

    // Widened so level*step can exceed the base without wrapping.
    assign base_w   = W'(BASE_PERIOD);
    assign min_w    = W'(MIN_PERIOD);
    assign reduce_w = W'(level_i) * W'(PERIOD_STEP);

    always_comb begin
        lvl_w = base_w - reduce_w;
        if ((reduce_w >= base_w) || (lvl_w < min_w)) begin
            lvl_w = min_w;
        end
        lvl_p_d = CNT_W'(lvl_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_p_q <= CNT_W'(BASE_PERIOD);
        end else begin
            lvl_p_q <= lvl_p_d;
        end
    end

    always_comb begin
        fast_p = lvl_p_q >> FAST_SHIFT;
        if (fast_p < CNT_W'(2)) begin
            fast_p = CNT_W'(2);
        end
        eff_p_o = soft_drop_i ? fast_p : lvl_p_q;
    end

endmodule

// File: rtl/game_tick_gen.sv
// Gravity tick generator: IDLE/RUN/PAUSED FSM, period counter and tick counter.
// Tick is registered, so it appears eff_p cycles after the RUN entry cycle.
module game_tick_gen
    import game_timing_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          LEVEL_W     = 4,
    parameter int unsigned BASE_PERIOD = DEF_BASE_PERIOD,
    parameter int unsigned PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int unsigned FAST_SHIFT  = DEF_FAST_SHIFT,
    parameter int          TCNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               pause_i,
    input  logic [LEVEL_W-1:0] level_i,
    input  logic               soft_drop_i,
    input  logic               resync_i,
    output logic               tick_o,
    output logic [TCNT_W-1:0]  tick_count_o,
    output logic               running_o,
    output logic               paused_o
);

    tick_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [CNT_W-1:0]  eff_p;

    tick_period_calc #(
        .CNT_W      (CNT_W),
        .LEVEL_W    (LEVEL_W),
        .BASE_PERIOD(BASE_PERIOD),
        .PERIOD_STEP(PERIOD_STEP),
        .MIN_PERIOD (MIN_PERIOD),
        .FAST_SHIFT (FAST_SHIFT)
    ) u_period (
        .clk        (clk),
        .rst        (rst),
        .level_i    (level_i),
        .soft_drop_i(soft_drop_i),
        .eff_p_o    (eff_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        tcnt_d  = tcnt_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = RUN;
                    tcnt_d  = '0;
                end
            end
            RUN: begin
                if (pause_i) begin
                    state_d = PAUSED;
                end
                // >= (not ==) so a shrinking period fires at once instead of wrapping.
                if (resync_i) begin
                    cnt_d = '0;
                end else if (!pause_i) begin
                    if (cnt_q >= eff_p - CNT_W'(1)) begin
                        tick_d = 1'b1;
                        cnt_d  = '0;
                        tcnt_d = tcnt_q + TCNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PAUSED: begin
                if (!pause_i) begin
                    state_d = RUN;
                end
                if (resync_i) begin
                    cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign tick_o       = tick_q;
    assign tick_count_o = tcnt_q;
    assign running_o    = (state_q == RUN);
    assign paused_o     = (state_q == PAUSED);

endmodule

// File: tb/tb_game_tick_gen.sv
// Scoreboard bench for game_tick_gen: each scenario pushes the expected tick
// cycles and tick counts; a monitor pops and compares every observed tick.
module tb_game_tick_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_i;
    logic       pause_i;
    logic [3:0] level_i;
    logic       soft_drop_i;
    logic       resync_i;
    logic       tick_o;
    logic [2:0] tick_count_o;
    logic       running_o;
    logic       paused_o;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   e0;

    game_tick_gen #(
        .CNT_W      (32),
        .LEVEL_W    (4),
        .BASE_PERIOD(20),
        .PERIOD_STEP(4),
        .MIN_PERIOD (4),
        .FAST_SHIFT (1),
        .TCNT_W     (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .pause_i     (pause_i),
        .level_i     (level_i),
        .soft_drop_i (soft_drop_i),
        .resync_i    (resync_i),
        .tick_o      (tick_o),
        .tick_count_o(tick_count_o),
        .running_o   (running_o),
        .paused_o    (paused_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (tick_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_tick", longint'(tick_o), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("tick_cyc", cyc, mon_e.cyc);
                check("tick_cnt", longint'(tick_count_o), mon_e.cnt);
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) edges(1);
    endtask

    task automatic push_tick(input int c, input int k);
        exp_t e;
        e.cyc = c;
        e.cnt = k % 8;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        edges(2);
        rst = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        edges(1);
        start_i = 1'b0;
        e0 = cyc;
    endtask

    task automatic check_drained(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; pause_i = 1'b0; level_i = 4'd0;
        soft_drop_i = 1'b0; resync_i = 1'b0;
        edges(3);
        rst = 1'b0;
        check("rst_tick", tick_o, 0);
        check("rst_tcnt", tick_count_o, 0);
        check("rst_running", running_o, 0);
        check("rst_paused", paused_o, 0);
        level_i = 4'd5; soft_drop_i = 1'b1;
        edges(30);
        check("idle_running", running_o, 0);
        level_i = 4'd0; soft_drop_i = 1'b0;
        edges(2);

        // Basic period; a start pulse mid-run must be ignored.
        do_start();
        push_tick(e0 + 20, 1); push_tick(e0 + 40, 2); push_tick(e0 + 60, 3);
        wait_to(e0 + 25);
        check("run_running", running_o, 1);
        check("run_paused", paused_o, 0);
        do_start();
        wait_to(e0 + 42);
        check_drained("basic_missing");

        // Level 3 -> 8, then 7 -> floor 4 (immediate tick), then 15 -> 4.
        do_reset();
        level_i = 4'd3;
        edges(2);
        do_start();
        push_tick(e0 + 8, 1); push_tick(e0 + 16, 2);
        push_tick(e0 + 20, 3); push_tick(e0 + 24, 4);
        push_tick(e0 + 28, 5); push_tick(e0 + 32, 6);
        wait_to(e0 + 18);
        level_i = 4'd7;
        wait_to(e0 + 24);
        level_i = 4'd15;
        wait_to(e0 + 34);
        check_drained("level_missing");

        // Soft drop at count 12 of 20, then release.
        do_reset();
        level_i = 4'd0;
        edges(2);
        do_start();
        wait_to(e0 + 12);
        soft_drop_i = 1'b1;
        push_tick(e0 + 13, 1); push_tick(e0 + 23, 2); push_tick(e0 + 33, 3);
        push_tick(e0 + 53, 4);
        wait_to(e0 + 33);
        soft_drop_i = 1'b0;
        wait_to(e0 + 56);
        check_drained("soft_missing");

        // Pause at count 5 for 30 cycles.
        do_reset();
        do_start();
        push_tick(e0 + 51, 1);
        wait_to(e0 + 5);
        pause_i = 1'b1;
        wait_to(e0 + 20);
        check("pause_paused", paused_o, 1);
        check("pause_running", running_o, 0);
        wait_to(e0 + 35);
        pause_i = 1'b0;
        wait_to(e0 + 37);
        check("resume_running", running_o, 1);
        check("resume_paused", paused_o, 0);
        wait_to(e0 + 53);
        check_drained("pause_missing");

        // Resync on the cycle the counter sits at 19.
        do_reset();
        do_start();
        wait_to(e0 + 19);
        resync_i = 1'b1;
        edges(1);
        resync_i = 1'b0;
        push_tick(e0 + 40, 1);
        wait_to(e0 + 42);
        check_drained("resync_missing");

        // start with pause in IDLE, then reset while PAUSED.
        do_reset();
        pause_i = 1'b1;
        do_start();
        push_tick(e0 + 27, 1);
        check("pstart_running", running_o, 1);
        edges(1);
        check("pstart_paused", paused_o, 1);
        wait_to(e0 + 6);
        pause_i = 1'b0;
        wait_to(e0 + 28);
        pause_i = 1'b1;
        edges(2);
        check("prst_paused_before", paused_o, 1);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        check("prst_paused", paused_o, 0);
        check("prst_running", running_o, 0);
        pause_i = 1'b0;
        edges(3);
        check_drained("pstart_missing");

        // Nine ticks wrap the 3-bit count to 1; reset mid-period beats start.
        do_reset();
        level_i = 4'd15;
        edges(2);
        do_start();
        for (int k = 1; k <= 9; k++) push_tick(e0 + 4 * k, k);
        wait_to(e0 + 38);
        check("wrap_tcnt", tick_count_o, 1);
        rst = 1'b1; start_i = 1'b1;
        edges(1);
        rst = 1'b0; start_i = 1'b0;
        check("mrst_tick", tick_o, 0);
        check("mrst_tcnt", tick_count_o, 0);
        check("mrst_running", running_o, 0);
        check("mrst_paused", paused_o, 0);
        edges(12);
        check("mrst_idle", running_o, 0);
        check_drained("wrap_missing");

        edges(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
